// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational IN_W-input function through every input vector and checks the result.
// Optional first-mismatch reporting is enabled by defining TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN.
module truth_table_sequencer #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1 << IN_W)-1:0]  expected,
  output logic [IN_W-1:0]         f_in,
  input  logic                    f_y,
  output logic                    busy,
  output logic                    done,
  output logic [(1 << IN_W)-1:0]  table_out,
  output logic                    pass
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
  ,
  output logic                    first_fail_vld,
  output logic [IN_W-1:0]         first_fail_idx
`endif
);

  localparam int unsigned TBL_W = 1 << IN_W;
  localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [IN_W-1:0]  LAST_VEC = {IN_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt,   w_cnt_d;
  logic [IN_W-1:0]  r_f_in,  w_f_in_d;
  logic [TBL_W-1:0] r_exp,   w_exp_d;
  logic [TBL_W-1:0] r_table, w_table_d;
  logic             r_busy,  w_busy_d;
  logic             r_done,  w_done_d;
  logic             r_pass,  w_pass_d;

`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
  logic             r_ff_vld, w_ff_vld_d;
  logic [IN_W-1:0]  r_ff_idx, w_ff_idx_d;
  logic             w_mismatch;

  assign w_mismatch = (f_y != r_exp[r_f_in]);
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_f_in_d  = r_f_in;
    w_exp_d   = r_exp;
    w_table_d = r_table;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_pass_d  = r_pass;
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
    w_ff_vld_d = r_ff_vld;
    w_ff_idx_d = r_ff_idx;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_exp_d   = expected;
          w_f_in_d  = '0;
          w_table_d = '0;
          w_pass_d  = 1'b0;
          w_cnt_d   = CNT_LOAD;
          w_busy_d  = 1'b1;
          w_state_d = ST_RUN;
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
          w_ff_vld_d = 1'b0;
          w_ff_idx_d = '0;
`endif
        end
      end

      ST_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else begin
          w_table_d[r_f_in] = f_y;
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
          // Vectors are visited in ascending order, so the first hit is the lowest index.
          if (w_mismatch && !r_ff_vld) begin
            w_ff_vld_d = 1'b1;
            w_ff_idx_d = r_f_in;
          end
`endif
          if (r_f_in == LAST_VEC) begin
            w_state_d = ST_FIN;
          end else begin
            w_f_in_d = r_f_in + IN_W'(1);
            w_cnt_d  = CNT_LOAD;
          end
        end
      end

      ST_FIN: begin
        // Table already holds the last sample, entered on the transition into this state.
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_pass_d  = (r_table == r_exp);
        w_state_d = ST_IDLE;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_f_in  <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_f_in  <= w_f_in_d;
      r_exp   <= w_exp_d;
      r_table <= w_table_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_pass  <= w_pass_d;
    end
  end

`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_vld <= 1'b0;
      r_ff_idx <= '0;
    end else begin
      r_ff_vld <= w_ff_vld_d;
      r_ff_idx <= w_ff_idx_d;
    end
  end

  assign first_fail_vld = r_ff_vld;
  assign first_fail_idx = r_ff_idx;
`endif

  assign f_in      = r_f_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign pass      = r_pass;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a SETTLE=1 instance driving a majority function and a
// SETTLE=0 instance driving XOR3, checked every cycle against a sweep-position model.
module tb_truth_table_sequencer;

  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] exp0 = 8'h00, exp1 = 8'h00;
  logic [2:0] fin0, fin1;
  logic       y0, y1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tab0, tab1;
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [2:0] ffi0, ffi1;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  function automatic logic fn(input int id, input logic [2:0] v);
    if (id == 0) return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    return ^v;
  endfunction

  assign y0 = fn(0, fin0);
  assign y1 = fn(1, fin1);

  truth_table_sequencer #(.IN_W(3), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .expected(exp0), .f_in(fin0), .f_y(y0),
    .busy(busy0), .done(done0), .table_out(tab0), .pass(pass0)
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
    , .first_fail_vld(ffv0), .first_fail_idx(ffi0)
`endif
  );

  truth_table_sequencer #(.IN_W(3), .SETTLE(0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .expected(exp1), .f_in(fin1), .f_y(y1),
    .busy(busy1), .done(done1), .table_out(tab1), .pass(pass1)
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
    , .first_fail_vld(ffv1), .first_fail_idx(ffi1)
`endif
  );

  // Model: position in the sweep counted in clock edges since the accepting edge.
  int         settle_of [2] = '{1, 0};
  bit         m_act [2];
  int         m_k [2];
  int         n_done [2];
  logic [7:0] m_exp [2];
  logic [7:0] e_tab [2];
  logic [2:0] e_fin [2];
  logic [2:0] e_ffi [2];
  logic       e_busy [2], e_done [2], e_pass [2], e_ffv [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic mreset(input int id);
    m_act[id]  = 1'b0;
    m_k[id]    = 0;
    m_exp[id]  = '0;
    e_tab[id]  = '0;
    e_fin[id]  = '0;
    e_busy[id] = 1'b0;
    e_done[id] = 1'b0;
    e_pass[id] = 1'b0;
    e_ffv[id]  = 1'b0;
    e_ffi[id]  = '0;
  endtask

  task automatic madv(input int id, input logic st, input logic [7:0] ex);
    int per = settle_of[id] + 1;
    int lat = TW * per + 1;
    int j;
    int idx;
    logic y;
    if (!m_act[id] || m_k[id] == lat) begin
      e_done[id] = 1'b0;
      if (st) begin
        m_act[id]  = 1'b1;
        m_k[id]    = 0;
        m_exp[id]  = ex;
        e_tab[id]  = '0;
        e_fin[id]  = '0;
        e_pass[id] = 1'b0;
        e_busy[id] = 1'b1;
        e_ffv[id]  = 1'b0;
        e_ffi[id]  = '0;
      end else begin
        m_act[id] = 1'b0;
      end
    end else begin
      m_k[id]++;
      j = m_k[id];
      if (j % per == 0 && j <= TW * per) begin
        idx = j / per - 1;
        y = fn(id, 3'(idx));
        e_tab[id][idx] = y;
        if (y != m_exp[id][idx] && !e_ffv[id]) begin
          e_ffv[id] = 1'b1;
          e_ffi[id] = 3'(idx);
        end
      end
      e_fin[id] = 3'((j / per < TW) ? j / per : TW - 1);
      if (j == lat) begin
        e_done[id] = 1'b1;
        e_busy[id] = 1'b0;
        e_pass[id] = (e_tab[id] == m_exp[id]);
      end
    end
  endtask

  task automatic step(input int id, input logic r, input logic st, input logic [7:0] ex,
                      input logic [2:0] fi, input logic bu, input logic dn,
                      input logic [7:0] tb, input logic ps);
    if (r) mreset(id);
    if (chk_en) begin
      chk($sformatf("dut%0d f_in", id), 32'(fi), 32'(e_fin[id]));
      chk($sformatf("dut%0d busy", id), 32'(bu), 32'(e_busy[id]));
      chk($sformatf("dut%0d done", id), 32'(dn), 32'(e_done[id]));
      chk($sformatf("dut%0d table_out", id), 32'(tb), 32'(e_tab[id]));
      chk($sformatf("dut%0d pass", id), 32'(ps), 32'(e_pass[id]));
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
      chk($sformatf("dut%0d first_fail_vld", id), 32'(id == 0 ? ffv0 : ffv1), 32'(e_ffv[id]));
      chk($sformatf("dut%0d first_fail_idx", id), 32'(id == 0 ? ffi0 : ffi1), 32'(e_ffi[id]));
`endif
      if (dn) n_done[id]++;
    end
    if (!r) madv(id, st, ex);
  endtask

  always @(negedge clk) begin
    step(0, rst0, start0, exp0, fin0, busy0, done0, tab0, pass0);
    step(1, rst1, start1, exp1, fin1, busy1, done1, tab1, pass1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(id == 0 ? done0 : done1) && n < budget);
    chk($sformatf("dut%0d done_seen", id), 32'(id == 0 ? done0 : done1), 32'd1);
  endtask

  task automatic pulse0(input logic [7:0] ex);
    exp0 = ex;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    mreset(0);
    mreset(1);
    n_done[0] = 0;
    n_done[1] = 0;
    repeat (2) tick();
    chk_en = 1'b1;
    chk("reset f_in", 32'(fin0), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset table", 32'(tab0), 32'd0);
    chk("reset pass", 32'(pass0), 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick();

    // Majority, matching expectation.
    pulse0(8'hE8);
    wait_done(0, 40, n);
    chk("t1 latency", 32'(n), 32'd17);
    chk("t1 table", 32'(tab0), 32'hE8);
    chk("t1 pass", 32'(pass0), 32'd1);
    chk("t1 busy", 32'(busy0), 32'd0);
    chk("t1 model pass", 32'(e_pass[0]), 32'd1);
    tick();
    chk("t1 hold table", 32'(tab0), 32'hE8);
    chk("t1 hold pass", 32'(pass0), 32'd1);
    chk("t1 done pulse", 32'(done0), 32'd0);

    // Expectation off by bit 0.
    pulse0(8'hE9);
    wait_done(0, 40, n);
    chk("t2 table", 32'(tab0), 32'hE8);
    chk("t2 pass", 32'(pass0), 32'd0);
    chk("t2 model pass", 32'(e_pass[0]), 32'd0);
`ifdef TRUTH_TABLE_SEQUENCER_FIRST_FAIL_EN
    chk("t2 ff_vld", 32'(ffv0), 32'd1);
    chk("t2 ff_idx", 32'(ffi0), 32'd0);
`endif
    tick();

    // Stray starts and a changing expected input during the sweep.
    pulse0(8'hE8);
    base = n_done[0];
    for (int c = 1; c <= 30; c++) begin
      start0 = (c == 3 || c == 9);
      if (c == 5) exp0 = 8'h00;
      tick();
    end
    start0 = 1'b0;
    chk("t3 one done", 32'(n_done[0] - base), 32'd1);
    chk("t3 pass", 32'(pass0), 32'd1);

    // Reset mid-sweep.
    pulse0(8'hE8);
    repeat (6) tick();
    rst0 = 1'b1;
    #1;
    chk("t4 rst busy", 32'(busy0), 32'd0);
    chk("t4 rst f_in", 32'(fin0), 32'd0);
    chk("t4 rst table", 32'(tab0), 32'd0);
    base = n_done[0];
    repeat (2) tick();
    rst0 = 1'b0;
    repeat (20) tick();
    chk("t4 no done", 32'(n_done[0] - base), 32'd0);
    pulse0(8'hE8);
    wait_done(0, 40, n);
    chk("t4 latency", 32'(n), 32'd17);
    chk("t4 pass", 32'(pass0), 32'd1);

    // SETTLE=0 with start held high: back-to-back sweeps.
    exp1 = 8'h96;
    start1 = 1'b1;
    tick();
    wait_done(1, 20, n);
    chk("t5 latency", 32'(n), 32'd9);
    chk("t5 pass", 32'(pass1), 32'd1);
    chk("t5 table", 32'(tab1), 32'h96);
    tick();
    chk("t5 restart table", 32'(tab1), 32'd0);
    chk("t5 restart busy", 32'(busy1), 32'd1);
    repeat (19) tick();
    start1 = 1'b0;
    repeat (15) tick();
    chk("t5 done count", 32'(n_done[1]), 32'd3);
    chk("t5 final pass", 32'(pass1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
